// File: rtl/id_ex_alu_issue_pkg.sv
// Shared RV32I constants for the ID/EX issue slice: ALU control codes,
// base opcodes and the bundle of control bits carried into EX.
package rv32_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_LW  = 3'b010;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic branch;
   } ex_ctrl_t;

   localparam ex_ctrl_t CTRL_NONE = '{reg_write: 1'b0, mem_read: 1'b0,
                                      mem_write: 1'b0, branch: 1'b0};

endpackage

// File: rtl/id_ex_alu_issue_if.sv
// Decode-stage instruction bus into the ID/EX register: validity, opcode
// fields, register-file operands, immediate and register addresses.
interface id_ex_alu_issue_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
);
   logic              id_valid;
   logic [6:0]        id_opcode;
   logic [2:0]        id_funct3;
   logic              id_funct7b5;
   logic [XLEN-1:0]   id_rs1_data;
   logic [XLEN-1:0]   id_rs2_data;
   logic [XLEN-1:0]   id_imm;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic [REG_AW-1:0] id_rd;

   modport master (
      output id_valid, id_opcode, id_funct3, id_funct7b5,
             id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd
   );

   modport slave (
      input  id_valid, id_opcode, id_funct3, id_funct7b5,
             id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd
   );
endinterface

// File: rtl/id_ex_alu_issue_decode.sv
// Combinational RV32I decode of opcode/funct fields into the ALU control
// code, operand-B source select, EX control bits and a supported flag.
module alu_ctrl_decode
   import rv32_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [2:0] alu_ctrl,
   output logic       alusrc,
   output ex_ctrl_t   ctrl,
   output logic       supported
);

   logic [2:0] alu_raw_s;
   logic       alusrc_raw_s;
   ex_ctrl_t   ctrl_raw_s;
   logic       ok_s;

   // Per-opcode decode; unsupported combinations are squashed below.
   always_comb begin
      alu_raw_s    = ALU_ADD;
      alusrc_raw_s = 1'b0;
      ctrl_raw_s   = CTRL_NONE;
      ok_s         = 1'b0;
      case (opcode)
         OP_R: begin
            ctrl_raw_s.reg_write = 1'b1;
            case (funct3)
               F3_ADD: begin
                  alu_raw_s = funct7b5 ? ALU_SUB : ALU_ADD;
                  ok_s      = 1'b1;
               end
               F3_AND: begin
                  alu_raw_s = ALU_AND;
                  ok_s      = !funct7b5;
               end
               F3_OR: begin
                  alu_raw_s = ALU_OR;
                  ok_s      = !funct7b5;
               end
               F3_SLT: begin
                  alu_raw_s = ALU_SLT;
                  ok_s      = !funct7b5;
               end
               default: ok_s = 1'b0;
            endcase
         end
         // funct7b5 is an immediate bit here, so it does not qualify the op.
         OP_I: begin
            alusrc_raw_s         = 1'b1;
            ctrl_raw_s.reg_write = 1'b1;
            case (funct3)
               F3_ADD:  begin alu_raw_s = ALU_ADD; ok_s = 1'b1; end
               F3_AND:  begin alu_raw_s = ALU_AND; ok_s = 1'b1; end
               F3_OR:   begin alu_raw_s = ALU_OR;  ok_s = 1'b1; end
               F3_SLT:  begin alu_raw_s = ALU_SLT; ok_s = 1'b1; end
               default: ok_s = 1'b0;
            endcase
         end
         OP_LOAD: begin
            alusrc_raw_s         = 1'b1;
            ctrl_raw_s.reg_write = 1'b1;
            ctrl_raw_s.mem_read  = 1'b1;
            ok_s                 = (funct3 == F3_LW);
         end
         OP_STORE: begin
            alusrc_raw_s         = 1'b1;
            ctrl_raw_s.mem_write = 1'b1;
            ok_s                 = (funct3 == F3_LW);
         end
         OP_BRANCH: begin
            alu_raw_s         = ALU_SUB;
            ctrl_raw_s.branch = 1'b1;
            ok_s              = (funct3 == F3_ADD) || (funct3 == F3_BNE);
         end
         default: ok_s = 1'b0;
      endcase
   end

   assign supported = ok_s;
   assign alu_ctrl  = ok_s ? alu_raw_s    : ALU_ADD;
   assign alusrc    = ok_s ? alusrc_raw_s : 1'b0;
   assign ctrl      = ok_s ? ctrl_raw_s   : CTRL_NONE;

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register feeding the ALU: decodes RV32I ALU ops, registers
// operands and control, and forwards EX/MEM and MEM/WB results onto A/B.
module id_ex_alu_issue
   import rv32_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   id_ex_alu_issue_if.slave  id_bus,
   input  logic              hold,
   input  logic              flush,
   input  logic [REG_AW-1:0] exm_rd,
   input  logic              exm_reg_write,
   input  logic [XLEN-1:0]   exm_result,
   input  logic [REG_AW-1:0] mwb_rd,
   input  logic              mwb_reg_write,
   input  logic [XLEN-1:0]   mwb_result,
   output logic [XLEN-1:0]   A,
   output logic [XLEN-1:0]   B,
   output logic [2:0]        ALU_ctrl,
   output logic              ex_valid,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_branch,
   output logic [XLEN-1:0]   ex_rs2_fwd,
   output logic              ex_illegal,
   output logic [31:0]       issue_count
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [XLEN-1:0]   rs1_data;
      logic [XLEN-1:0]   rs2_data;
      logic [XLEN-1:0]   imm;
      logic [2:0]        alu_ctrl;
      logic              alusrc;
      ex_ctrl_t          ctrl;
   } stage_t;

   // Youngest matching writer wins; x0 is never a forwarding target.
   function automatic logic [XLEN-1:0] fwd_sel(
      input logic [REG_AW-1:0] rs,
      input logic [XLEN-1:0]   rf_data,
      input logic [REG_AW-1:0] e_rd,
      input logic              e_we,
      input logic [XLEN-1:0]   e_val,
      input logic [REG_AW-1:0] w_rd,
      input logic              w_we,
      input logic [XLEN-1:0]   w_val
   );
      logic [XLEN-1:0] sel;
      if (e_we && (e_rd != {REG_AW{1'b0}}) && (e_rd == rs)) begin
         sel = e_val;
      end else if (w_we && (w_rd != {REG_AW{1'b0}}) && (w_rd == rs)) begin
         sel = w_val;
      end else begin
         sel = rf_data;
      end
      return sel;
   endfunction

   logic [2:0]      dec_alu_ctrl_s;
   logic            dec_alusrc_s;
   ex_ctrl_t        dec_ctrl_s;
   logic            dec_supported_s;
   stage_t          stage_load_s;
   stage_t          stage_r;
   logic            illegal_r;
   logic [31:0]     issue_count_r;
   logic [XLEN-1:0] rs1_fwd_s;
   logic [XLEN-1:0] rs2_fwd_s;

   alu_ctrl_decode u_decode (
      .opcode    (id_bus.id_opcode),
      .funct3    (id_bus.id_funct3),
      .funct7b5  (id_bus.id_funct7b5),
      .alu_ctrl  (dec_alu_ctrl_s),
      .alusrc    (dec_alusrc_s),
      .ctrl      (dec_ctrl_s),
      .supported (dec_supported_s)
   );

   // Next stage contents for a normal load; an unsupported valid op becomes a bubble.
   always_comb begin
      stage_load_s = '0;
      if (id_bus.id_valid && !dec_supported_s) begin
         stage_load_s = '0;
      end else begin
         stage_load_s.valid    = id_bus.id_valid;
         stage_load_s.rd       = id_bus.id_rd;
         stage_load_s.rs1      = id_bus.id_rs1;
         stage_load_s.rs2      = id_bus.id_rs2;
         stage_load_s.rs1_data = id_bus.id_rs1_data;
         stage_load_s.rs2_data = id_bus.id_rs2_data;
         stage_load_s.imm      = id_bus.id_imm;
         stage_load_s.alu_ctrl = dec_alu_ctrl_s;
         stage_load_s.alusrc   = dec_alusrc_s;
         stage_load_s.ctrl     = id_bus.id_valid ? dec_ctrl_s : CTRL_NONE;
         stage_load_s.ctrl.reg_write = stage_load_s.ctrl.reg_write &&
                                       (id_bus.id_rd != {REG_AW{1'b0}});
      end
   end

   // ID/EX register: flush beats hold beats load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_r <= '0;
      end else if (flush) begin
         stage_r <= '0;
      end else if (hold) begin
         stage_r <= stage_r;
      end else begin
         stage_r <= stage_load_s;
      end
   end

   // Illegal pulse lasts one cycle even if the stage then freezes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_r     <= 1'b0;
         issue_count_r <= 32'd0;
      end else if (flush || hold) begin
         illegal_r     <= 1'b0;
         issue_count_r <= issue_count_r;
      end else begin
         illegal_r     <= id_bus.id_valid && !dec_supported_s;
         issue_count_r <= stage_load_s.valid ? issue_count_r + 32'd1 : issue_count_r;
      end
   end

   // Forwarding stays live while held, since producers keep retiring.
   always_comb begin
      rs1_fwd_s = fwd_sel(stage_r.rs1, stage_r.rs1_data, exm_rd, exm_reg_write,
                          exm_result, mwb_rd, mwb_reg_write, mwb_result);
      rs2_fwd_s = fwd_sel(stage_r.rs2, stage_r.rs2_data, exm_rd, exm_reg_write,
                          exm_result, mwb_rd, mwb_reg_write, mwb_result);
   end

   assign A            = rs1_fwd_s;
   assign B            = stage_r.alusrc ? stage_r.imm : rs2_fwd_s;
   assign ex_rs2_fwd   = rs2_fwd_s;
   assign ALU_ctrl     = stage_r.alu_ctrl;
   assign ex_valid     = stage_r.valid;
   assign ex_rd        = stage_r.rd;
   assign ex_reg_write = stage_r.ctrl.reg_write;
   assign ex_mem_read  = stage_r.ctrl.mem_read;
   assign ex_mem_write = stage_r.ctrl.mem_write;
   assign ex_branch    = stage_r.ctrl.branch;
   assign ex_illegal   = illegal_r;
   assign issue_count  = issue_count_r;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Randomized bench for id_ex_alu_issue with an in-bench reference model,
// a per-cycle compare process and directed literal checks.
module tb_id_ex_alu_issue;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hold = 1'b0;
   logic        flush = 1'b0;
   logic [4:0]  exm_rd = 5'd0;
   logic        exm_reg_write = 1'b0;
   logic [31:0] exm_result = 32'd0;
   logic [4:0]  mwb_rd = 5'd0;
   logic        mwb_reg_write = 1'b0;
   logic [31:0] mwb_result = 32'd0;

   logic [31:0] A, B, ex_rs2_fwd, issue_count;
   logic [2:0]  ALU_ctrl;
   logic [4:0]  ex_rd;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;

   int n_checks = 0;
   int n_fail = 0;
   bit checking = 1'b0;

   id_ex_alu_issue_if #(.XLEN(XLEN), .REG_AW(REG_AW)) id_bus ();

   id_ex_alu_issue #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst_n(rst_n), .id_bus(id_bus), .hold(hold), .flush(flush),
      .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
      .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
      .A(A), .B(B), .ALU_ctrl(ALU_ctrl), .ex_valid(ex_valid), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
      .ex_rs2_fwd(ex_rs2_fwd), .ex_illegal(ex_illegal), .issue_count(issue_count)
   );

   always #5 clk = ~clk;

   // Reference state: what EX holds, as plain variables.
   logic        m_valid = 1'b0, m_useimm = 1'b0, m_rw = 1'b0, m_mr = 1'b0;
   logic        m_mw = 1'b0, m_br = 1'b0, m_ill = 1'b0;
   logic [4:0]  m_rd = 5'd0, m_rs1 = 5'd0, m_rs2 = 5'd0;
   logic [31:0] m_rs1d = 32'd0, m_rs2d = 32'd0, m_imm = 32'd0, m_cnt = 32'd0;
   logic [2:0]  m_alu = 3'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ALU code for the four funct3 values shared by R and I types.
   function automatic logic f3_alu(input logic [2:0] f3, output logic [2:0] alu);
      case (f3)
         3'b000:  begin alu = 3'b000; return 1'b1; end
         3'b111:  begin alu = 3'b010; return 1'b1; end
         3'b110:  begin alu = 3'b011; return 1'b1; end
         3'b010:  begin alu = 3'b101; return 1'b1; end
         default: begin alu = 3'b000; return 1'b0; end
      endcase
   endfunction

   function automatic void ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                      output logic ok, output logic [2:0] alu, output logic useimm,
                                      output logic rw, output logic mr, output logic mw,
                                      output logic br);
      logic [2:0] a;
      logic       known;
      known = f3_alu(f3, a);
      ok = 1'b0; alu = 3'b000; useimm = 1'b0; rw = 1'b0; mr = 1'b0; mw = 1'b0; br = 1'b0;
      if (op == 7'b0110011) begin
         ok = known && (f3 == 3'b000 || !f7);
         alu = (f3 == 3'b000 && f7) ? 3'b001 : a;
         rw = 1'b1;
      end else if (op == 7'b0010011) begin
         ok = known; alu = a; useimm = 1'b1; rw = 1'b1;
      end else if (op == 7'b0000011) begin
         ok = (f3 == 3'b010); useimm = 1'b1; rw = 1'b1; mr = 1'b1;
      end else if (op == 7'b0100011) begin
         ok = (f3 == 3'b010); useimm = 1'b1; mw = 1'b1;
      end else if (op == 7'b1100011) begin
         ok = (f3 == 3'b000 || f3 == 3'b001); alu = 3'b001; br = 1'b1;
      end
      if (!ok) begin
         alu = 3'b000; useimm = 1'b0; rw = 1'b0; mr = 1'b0; mw = 1'b0; br = 1'b0;
      end
   endfunction

   function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rf);
      if (exm_reg_write && exm_rd != 5'd0 && exm_rd == rs) return exm_result;
      if (mwb_reg_write && mwb_rd != 5'd0 && mwb_rd == rs) return mwb_result;
      return rf;
   endfunction

   function automatic void m_bubble();
      m_valid = 1'b0; m_useimm = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_br = 1'b0;
      m_rd = 5'd0; m_rs1 = 5'd0; m_rs2 = 5'd0; m_rs1d = 32'd0; m_rs2d = 32'd0;
      m_imm = 32'd0; m_alu = 3'd0;
   endfunction

   // Model update at each clock edge, cleared immediately by reset.
   always @(posedge clk or negedge rst_n) begin
      logic ok, ui, rw, mr, mw, br;
      logic [2:0] alu;
      if (!rst_n) begin
         m_bubble(); m_ill = 1'b0; m_cnt = 32'd0;
      end else if (flush) begin
         m_bubble(); m_ill = 1'b0;
      end else if (hold) begin
         m_ill = 1'b0;
      end else begin
         ref_decode(id_bus.id_opcode, id_bus.id_funct3, id_bus.id_funct7b5,
                    ok, alu, ui, rw, mr, mw, br);
         if (id_bus.id_valid && !ok) begin
            m_bubble(); m_ill = 1'b1;
         end else begin
            m_ill = 1'b0;
            m_valid = id_bus.id_valid;
            m_rd = id_bus.id_rd; m_rs1 = id_bus.id_rs1; m_rs2 = id_bus.id_rs2;
            m_rs1d = id_bus.id_rs1_data; m_rs2d = id_bus.id_rs2_data; m_imm = id_bus.id_imm;
            m_alu = alu; m_useimm = ui;
            m_rw = id_bus.id_valid && rw && (id_bus.id_rd != 5'd0);
            m_mr = id_bus.id_valid && mr;
            m_mw = id_bus.id_valid && mw;
            m_br = id_bus.id_valid && br;
            if (id_bus.id_valid) m_cnt = m_cnt + 32'd1;
         end
      end
   end

   // Compare every output against the model on the falling edge.
   always @(negedge clk) begin
      if (checking) begin
         chk("A", A, ref_fwd(m_rs1, m_rs1d));
         chk("B", B, m_useimm ? m_imm : ref_fwd(m_rs2, m_rs2d));
         chk("rs2_fwd", ex_rs2_fwd, ref_fwd(m_rs2, m_rs2d));
         chk("ALU_ctrl", {29'd0, ALU_ctrl}, {29'd0, m_alu});
         chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
         chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
         chk("ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch},
             {28'd0, m_rw, m_mr, m_mw, m_br});
         chk("ex_illegal", {31'd0, ex_illegal}, {31'd0, m_ill});
         chk("issue_count", issue_count, m_cnt);
      end
   end

   task automatic set_instr(input logic v, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] rd);
      id_bus.id_valid = v; id_bus.id_opcode = op; id_bus.id_funct3 = f3;
      id_bus.id_funct7b5 = f7; id_bus.id_rs1_data = d1; id_bus.id_rs2_data = d2;
      id_bus.id_imm = imm; id_bus.id_rs1 = r1; id_bus.id_rs2 = r2; id_bus.id_rd = rd;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   logic [6:0] ops [6];

   initial begin
      ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
      ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
      set_instr(1'b0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
      repeat (3) tick();
      chk("reset_A", A, 32'd0);
      chk("reset_ALU", {29'd0, ALU_ctrl}, 32'd0);
      chk("reset_valid", {31'd0, ex_valid}, 32'd0);
      chk("reset_count", issue_count, 32'd0);
      rst_n = 1'b1;
      checking = 1'b1;

      set_instr(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd5, 32'd3, 32'd0, 5'd3, 5'd4, 5'd1);
      tick();
      chk("add_A", A, 32'h0000_0005);
      chk("add_B", B, 32'h0000_0003);
      chk("add_ALU", {29'd0, ALU_ctrl}, 32'd0);
      chk("add_valid", {31'd0, ex_valid}, 32'd1);
      chk("add_count", issue_count, 32'd1);

      set_instr(1'b1, 7'b0110011, 3'b000, 1'b1, 32'h8000_0000, 32'd1, 32'd0, 5'd3, 5'd4, 5'd1);
      tick();
      chk("sub_ALU", {29'd0, ALU_ctrl}, 32'd1);
      chk("sub_A", A, 32'h8000_0000);
      chk("sub_B", B, 32'h0000_0001);

      set_instr(1'b1, 7'b0010011, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd7, 32'd1, 5'd3, 5'd4, 5'd1);
      tick();
      chk("slti_ALU", {29'd0, ALU_ctrl}, 32'd5);
      chk("slti_B", B, 32'h0000_0001);
      chk("slti_count", issue_count, 32'd3);

      set_instr(1'b1, 7'b0110011, 3'b000, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'd0,
                5'd2, 5'd4, 5'd6);
      tick();
      exm_rd = 5'd2; exm_reg_write = 1'b1; exm_result = 32'hAAAA_0000;
      mwb_rd = 5'd2; mwb_reg_write = 1'b1; mwb_result = 32'h1234_5678;
      #1;
      chk("fwd_exm", A, 32'hAAAA_0000);
      exm_rd = 5'd0;
      #1;
      chk("fwd_mwb", A, 32'h1234_5678);
      exm_reg_write = 1'b0; mwb_reg_write = 1'b0; mwb_rd = 5'd0;

      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_instr(1'b1, 7'b0110011, 3'b110, 1'b0, $urandom, $urandom, $urandom,
                   5'd9, 5'd10, 5'd11);
         tick();
         chk("hold_A", A, 32'h1111_1111);
         chk("hold_B", B, 32'h2222_2222);
         chk("hold_count", issue_count, 32'd4);
      end
      flush = 1'b1;
      tick();
      chk("flush_valid", {31'd0, ex_valid}, 32'd0);
      chk("flush_ALU", {29'd0, ALU_ctrl}, 32'd0);
      chk("flush_count", issue_count, 32'd4);
      flush = 1'b0; hold = 1'b0;

      set_instr(1'b1, 7'b0110011, 3'b100, 1'b0, 32'd9, 32'd9, 32'd0, 5'd1, 5'd1, 5'd5);
      tick();
      chk("xor_illegal", {31'd0, ex_illegal}, 32'd1);
      chk("xor_valid", {31'd0, ex_valid}, 32'd0);
      chk("xor_rw", {31'd0, ex_reg_write}, 32'd0);
      set_instr(1'b1, 7'b0000011, 3'b010, 1'b0, 32'd100, 32'd0, 32'd4, 5'd1, 5'd2, 5'd0);
      tick();
      chk("lw_illegal_drop", {31'd0, ex_illegal}, 32'd0);
      chk("lw_x0_rw", {31'd0, ex_reg_write}, 32'd0);
      chk("lw_mem_read", {31'd0, ex_mem_read}, 32'd1);
      chk("lw_B", B, 32'd4);
      chk("lw_count", issue_count, 32'd5);

      set_instr(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd7, 32'd8, 32'd0, 5'd1, 5'd2, 5'd3);
      tick();
      chk("pre_rst_A", A, 32'd7);
      rst_n = 1'b0;
      #1;
      chk("rst_A", A, 32'd0);
      chk("rst_B", B, 32'd0);
      chk("rst_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst_count", issue_count, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_count", issue_count, 32'd1);
      force dut.issue_count_r = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.issue_count_r;
      tick();
      chk("wrap_count", issue_count, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         set_instr($urandom_range(0, 3) != 0, ops[$urandom_range(0, 5)], 3'($urandom),
                   1'($urandom), $urandom, $urandom, $urandom, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         hold = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 15) == 0);
         exm_rd = 5'($urandom_range(0, 7)); exm_reg_write = 1'($urandom);
         exm_result = $urandom;
         mwb_rd = 5'($urandom_range(0, 7)); mwb_reg_write = 1'($urandom);
         mwb_result = $urandom;
         tick();
      end

      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
